key_event_decoder: RTL and testbench

- Consumes a raw, active-low push-button input and classifies each gesture into single-cycle event pulses: single click, double click, or long press.
- Sits where the debounced key flag is consumed, between the board button pins and the display/mode-control logic of the VGA monitor design.
- Runs on the 25 MHz pixel-domain clock.
- Contains its own synchronizer and two-edge debouncer, so it needs no upstream filter.

---
 rtl/key_event_decoder.sv | 162 ++++++++++++++++
 tb/tb_key_event_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Push-button gesture decoder: synchronizes and debounces an active-low key,
// then classifies each gesture as a single click, a double click or a long press.
module key_event_decoder #(
  parameter logic [31:0] deb_max  = 32'd499_999,
  parameter logic [31:0] long_max = 32'd24_999_999,
  parameter logic [31:0] dbl_max  = 32'd7_499_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_level,
  output logic click_flag,
  output logic dbl_flag,
  output logic long_flag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD1 = 3'd1,
    LONG  = 3'd2,
    GAP   = 3'd3,
    HOLD2 = 3'd4
  } state_t;

  logic [1:0]  sync_reg;
  logic        key_s;
  logic [31:0] deb_cnt_reg;
  logic [31:0] deb_cnt_next;
  logic        key_stable_reg;
  logic        key_stable_next;
  logic        key_stable_d_reg;
  logic        press_evt;
  logic        release_evt;
  logic        key_level_reg;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] tcnt_reg;
  logic        click_reg;
  logic        click_next;
  logic        dbl_reg;
  logic        dbl_next;
  logic        long_reg;
  logic        long_next;

  // Two-flop synchronizer; idles high so a released key looks stable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], key};
    end
  end

  assign key_s = sync_reg[1];

  // The stable level only follows key_s after deb_max+1 consecutive disagreeing cycles.
  always_comb begin
    deb_cnt_next    = deb_cnt_reg;
    key_stable_next = key_stable_reg;
    if (key_s == key_stable_reg) begin
      deb_cnt_next = 32'd0;
    end else if (deb_cnt_reg == deb_max) begin
      key_stable_next = key_s;
      deb_cnt_next    = 32'd0;
    end else begin
      deb_cnt_next = deb_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_reg      <= 32'd0;
      key_stable_reg   <= 1'b1;
      key_stable_d_reg <= 1'b1;
      key_level_reg    <= 1'b0;
    end else begin
      deb_cnt_reg      <= deb_cnt_next;
      key_stable_reg   <= key_stable_next;
      key_stable_d_reg <= key_stable_reg;
      key_level_reg    <= ~key_stable_reg;
    end
  end

  assign press_evt   = key_stable_d_reg & ~key_stable_reg;
  assign release_evt = ~key_stable_d_reg & key_stable_reg;

  // Edge events are tested before timer expiry so a boundary-cycle edge wins.
  always_comb begin
    state_next = state_reg;
    click_next = 1'b0;
    dbl_next   = 1'b0;
    long_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press_evt) begin
          state_next = HOLD1;
        end
      end
      HOLD1: begin
        if (release_evt) begin
          state_next = GAP;
        end else if (tcnt_reg == long_max) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      LONG: begin
        if (release_evt) begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (press_evt) begin
          state_next = HOLD2;
        end else if (tcnt_reg == dbl_max) begin
          state_next = IDLE;
          click_next = 1'b1;
        end
      end
      HOLD2: begin
        if (release_evt) begin
          state_next = IDLE;
          dbl_next   = 1'b1;
        end else if (tcnt_reg == long_max) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tcnt measures time spent in the current state and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tcnt_reg  <= 32'd0;
      click_reg <= 1'b0;
      dbl_reg   <= 1'b0;
      long_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        tcnt_reg <= 32'd0;
      end else if (tcnt_reg != 32'hFFFF_FFFF) begin
        tcnt_reg <= tcnt_reg + 32'd1;
      end
      click_reg <= click_next;
      dbl_reg   <= dbl_next;
      long_reg  <= long_next;
    end
  end

  assign key_level  = key_level_reg;
  assign click_flag = click_reg;
  assign dbl_flag   = dbl_reg;
  assign long_flag  = long_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a deadline-scheduling gesture model checked every
// cycle, plus hand-computed latencies and pulse counts for each directed gesture.
module tb_key_event_decoder;

  localparam int DEB = 3;
  localparam int LNG = 40;
  localparam int DBL = 20;

  localparam int G_NONE   = 0;
  localparam int G_FIRST  = 1;
  localparam int G_WAIT   = 2;
  localparam int G_SECOND = 3;
  localparam int G_LONG   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic key   = 1'b1;
  logic key_level;
  logic click_flag;
  logic dbl_flag;
  logic long_flag;

  key_event_decoder #(
    .deb_max (32'd3),
    .long_max(32'd40),
    .dbl_max (32'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_level (key_level),
    .click_flag(click_flag),
    .dbl_flag  (dbl_flag),
    .long_flag (long_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Debounced-level model: key as seen through two sample stages, and a run length
  // of cycles in which that delayed key disagrees with the accepted level.
  logic m_s0, m_s1, m_st, m_st_prev;
  int   m_run;
  // Gesture model: pending deadlines (absolute cycle numbers, -1 = none).
  int   mode;
  int   click_due, long_due, dbl_due;
  logic exp_level, exp_click, exp_dbl, exp_long;

  // Observations of the DUT, cleared per directed test.
  int   n_click, n_dbl, n_long, n_rise;
  int   t_click, t_dbl, t_long, t_level;
  logic prev_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function void model_reset();
    m_s0 = 1'b1; m_s1 = 1'b1; m_st = 1'b1; m_st_prev = 1'b1; m_run = 0;
    mode = G_NONE; click_due = -1; long_due = -1; dbl_due = -1;
    exp_level = 1'b0; exp_click = 1'b0; exp_dbl = 1'b0; exp_long = 1'b0;
  endfunction

  function void model_step(input int c, input logic k);
    logic st_before;
    logic press, rel;
    st_before = m_st;
    if (m_s1 != m_st) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_st  = m_s1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s1      = m_s0;
    m_s0      = k;
    m_st_prev = st_before;
    exp_level = !st_before;
    press     = m_st_prev && !m_st;
    rel       = !m_st_prev && m_st;

    exp_click = (click_due == c);
    exp_long  = (long_due == c);
    exp_dbl   = (dbl_due == c);
    if (exp_click) begin click_due = -1; mode = G_NONE; end
    if (exp_long)  begin long_due = -1;  mode = G_LONG; end
    if (exp_dbl)   dbl_due = -1;

    if (press) begin
      if (mode == G_NONE) begin
        mode = G_FIRST; long_due = c + LNG + 2;
      end else if (mode == G_WAIT) begin
        click_due = -1; mode = G_SECOND; long_due = c + LNG + 2;
      end
    end
    if (rel) begin
      if (mode == G_FIRST) begin
        long_due = -1; click_due = c + DBL + 2; mode = G_WAIT;
      end else if (mode == G_SECOND) begin
        long_due = -1; dbl_due = c + 1; mode = G_NONE;
      end else if (mode == G_LONG) begin
        mode = G_NONE;
      end
    end
  endfunction

  // Per-cycle compare, 1 ns after each rising edge.
  initial begin
    model_reset();
    prev_lvl = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) model_reset();
      else model_step(cyc, key);
      check($sformatf("key_level@%0d", cyc), {31'd0, key_level}, {31'd0, exp_level});
      check($sformatf("click_flag@%0d", cyc), {31'd0, click_flag}, {31'd0, exp_click});
      check($sformatf("dbl_flag@%0d", cyc), {31'd0, dbl_flag}, {31'd0, exp_dbl});
      check($sformatf("long_flag@%0d", cyc), {31'd0, long_flag}, {31'd0, exp_long});
      if (click_flag === 1'b1) begin n_click++; t_click = cyc; end
      if (dbl_flag === 1'b1)   begin n_dbl++;   t_dbl = cyc;   end
      if (long_flag === 1'b1)  begin n_long++;  t_long = cyc;  end
      if (key_level === 1'b1 && prev_lvl === 1'b0) begin n_rise++; t_level = cyc; end
      prev_lvl = key_level;
    end
  end

  task automatic clear_obs();
    n_click = 0; n_dbl = 0; n_long = 0; n_rise = 0;
    t_click = -1; t_dbl = -1; t_long = -1; t_level = -1;
  endtask

  // Drive key at a falling edge; e is the first rising edge that samples it.
  task automatic drive(input logic v, input int hold, output int e);
    @(negedge clk);
    key = v;
    e = cyc + 1;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_level"}, {31'd0, key_level}, 32'd0);
    check({tag, "_click"}, {31'd0, click_flag}, 32'd0);
    check({tag, "_dbl"}, {31'd0, dbl_flag}, 32'd0);
    check({tag, "_long"}, {31'd0, long_flag}, 32'd0);
  endtask

  initial begin
    int e0, e1, e2, e3, ed;
    clear_obs();
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5, ed);

    // Single click
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 60, e1);
    check("t1_level_latency", t_level, e0 + 6);
    check("t1_click_count", n_click, 1);
    check("t1_click_time", t_click, e1 + 27);
    check("t1_no_dbl_long", n_dbl + n_long, 0);
    $display("T1 single click: level@%0d click@%0d", t_level - e0, t_click - e1);

    // Glitches shorter than the debounce window
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3, ed);
      drive(1'b1, 3, ed);
    end
    drive(1'b1, 30, ed);
    check("t2_level_rises", n_rise, 0);
    check("t2_no_flags", n_click + n_dbl + n_long, 0);
    $display("T2 glitches: level rises %0d", n_rise);

    // Double click
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 8, e1);
    drive(1'b0, 10, e2);
    drive(1'b1, 40, e3);
    check("t3_dbl_count", n_dbl, 1);
    check("t3_dbl_time", t_dbl, e3 + 6);
    check("t3_no_click", n_click, 0);
    $display("T3 double click: dbl@%0d after release", t_dbl - e3);

    // Long press
    clear_obs();
    drive(1'b0, 100, e0);
    drive(1'b1, 40, e1);
    check("t4_long_count", n_long, 1);
    check("t4_long_time", t_long, e0 + 47);
    check("t4_no_click_dbl", n_click + n_dbl, 0);
    $display("T4 long press: long@%0d after press", t_long - e0);

    // Second press lands on the last cycle of the double-click window
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 21, e1);
    drive(1'b0, 10, e2);
    drive(1'b1, 40, e3);
    check("t5_no_click", n_click, 0);
    check("t5_dbl_count", n_dbl, 1);
    check("t5_dbl_time", t_dbl, e3 + 6);
    $display("T5 gap boundary: dbl@%0d clicks %0d", t_dbl - e3, n_click);

    // Second press one cycle too late: click, then a fresh gesture
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 22, e1);
    drive(1'b0, 10, e2);
    drive(1'b1, 60, e3);
    check("t6_click_count", n_click, 2);
    check("t6_click_time", t_click, e3 + 27);
    check("t6_no_dbl", n_dbl, 0);
    $display("T6 gap overrun: clicks %0d", n_click);

    // Release on the long-press boundary cycle beats the timer
    clear_obs();
    drive(1'b0, 41, e0);
    drive(1'b1, 60, e1);
    check("t7_no_long", n_long, 0);
    check("t7_click_time", t_click, e1 + 27);
    $display("T7 hold boundary: long %0d click@%0d", n_long, t_click - e1);

    // Release one cycle later: the long press wins
    clear_obs();
    drive(1'b0, 42, e0);
    drive(1'b1, 40, e1);
    check("t8_long_count", n_long, 1);
    check("t8_long_time", t_long, e0 + 47);
    check("t8_no_click", n_click, 0);
    $display("T8 hold overrun: long@%0d", t_long - e0);

    // Reset inside the gap, then a clean click
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 10, e1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_outputs_zero("t9_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 40, ed);
    check("t9_no_click_after_rst", n_click, 0);
    clear_obs();
    drive(1'b0, 10, e0);
    drive(1'b1, 60, e1);
    check("t9_click_time", t_click, e1 + 27);
    $display("T9 reset in gap: click@%0d", t_click - e1);

    // Reset while held: key_level drops at once, the held key is re-recognised
    clear_obs();
    drive(1'b0, 12, e0);
    check("t10_level_held", {31'd0, key_level}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("t10_level_rst", {31'd0, key_level}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (15) @(negedge clk);
    check("t10_level_again", {31'd0, key_level}, 32'd1);
    drive(1'b1, 60, e1);
    check("t10_click_count", n_click, 1);
    check("t10_click_time", t_click, e1 + 27);
    check("t10_no_long", n_long, 0);
    $display("T10 reset while held: click@%0d", t_click - e1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
